bullet_pool: RTL and testbench
==============================

Name: bullet_pool

Overview:
Multi-slot projectile manager for the tank game; successor to the single-bullet mover.
- Holds NUM_BULLETS independent bullet slots. Each slot is launched from the tank's current position and direction on a fire edge.
- Every active slot advances once per frame and retires at the screen edge or on an external hit.
- Sits between the keycode decoder / tank controller and the sprite renderer and collision logic.

Parameters:
NUM_BULLETS, 4, number of bullet slots (1..8)
STEP, 5, pixels moved per frame
X_MAX, 639, rightmost valid pixel column
Y_MAX, 479, bottom valid pixel row
BULLET_W, 8, bullet width in pixels
BULLET_H, 8, bullet height in pixels
COOLDOWN, 8, frames between launches (0 = none)

Ports:
frame_clk  in  1  frame-rate clock (one tick per video frame)
Reset  in  1  asynchronous, active-high
fire  in  1  fire key level; edge-detected internally
tank_x, tank_y  in  10 each  tank top-left
tank_sx, tank_sy  in  10 each  tank size
dir  in  2  tank direction: 00 up, 01 down, 10 left, 11 right
hit  in  NUM_BULLETS  per-slot kill request from collision logic
active  out  NUM_BULLETS  slot-valid mask
bullet_x, bullet_y  out  NUM_BULLETS*10 each  packed positions (slot i at [10i+9:10i])
bullet_dir  out  NUM_BULLETS*2  packed per-slot direction
fire_ack  out  1  high for exactly one frame after a launch
pool_full  out  1  all slots active (registered)

Behaviour:
- Reset value of every output and every internal register is 0.
- All state updates on posedge frame_clk.
- Fire edge:
  - fire_edge = fire & ~fire_q, where fire_q is the registered fire.
  - A launch occurs when fire_edge=1, cooldown=0, and at least one slot is free.
  - Free slots are judged on the registered active mask only. A slot freed in the same cycle is not reusable until the next cycle.
  - The lowest-index free slot is allocated.
- Spawn position, computed in 11-bit signed arithmetic:
  - x = tank_x + (tank_sx>>1) - (BULLET_W>>1)
  - y = tank_y + (tank_sy>>1) - (BULLET_H>>1)
  - A negative result clamps to 0.
- On launch:
  - The launch cycle loads position and dir and sets active.
  - The slot does not move in the launch cycle.
  - fire_ack=1 for the next frame.
  - cooldown is loaded with COOLDOWN.
- Dropped launch:
  - A fire edge with cooldown>0 or a full pool is dropped: no ack, cooldown untouched, no queueing.
- Cooldown: decrements by 1 per frame while nonzero and saturates at 0.
- Per active slot, each frame, in priority order:
  1. hit[i]=1: active cleared, position held.
  2. Edge check, using the current position:
     - up: y < STEP
     - down: y + BULLET_H + STEP > Y_MAX
     - left: x < STEP
     - right: x + BULLET_W + STEP > X_MAX
     - If the check is true, active is cleared.
  3. Otherwise the slot moves STEP in its direction.
- Inactive slots hold their position; hit is ignored for them.
- pool_full is registered: pool_full = &active_next.
- Reset asserted mid-flight clears all slots and cooldown immediately (asynchronously).

Optional Feature:
BULLET_AUTOFIRE_EN
- Defined: while fire is held high, a launch is attempted every frame in which cooldown=0. The edge detector is bypassed; all other launch conditions still apply.
- Undefined: launches occur only on a fire rising edge, as specified above.

Decomposition:
- Package bullet_pkg:
  - dir_t enum (DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT)
  - COORD_W = 10
  - screen bound constants
- Sub-module bullet_slot, one per slot, via a generate loop:
  - contents: position and direction registers, edge check, move logic
  - inputs: launch strobe, spawn x/y/dir, hit
  - outputs: active, x, y, dir
- The top level owns the edge detector, cooldown counter, priority allocator and packing.

Test Plan:
1. Tank (100,200), size 16x16, dir=up, fire pulse → next frame: active=0001, x0=104, y0=204, fire_ack=1 for one frame; the following frame y0=199.
2. Continue scenario 1 → y0 steps down by 5 each frame to 4; on the next frame active[0]=0 and y0 holds 4.
3. COOLDOWN=8, fire edges at frames 0 and 3 → only slot 0 launches; an edge at frame 9 launches slot 1.
4. COOLDOWN=0, four launches, then a fifth edge → pool_full=1, no ack, slots unchanged. Assert hit[2] → active=1011; the next edge allocates slot 2.
5. Tank (0,0), size 4x4, dir=left → spawn clamps to x=0, y=0; the next frame active clears (0 < STEP).
6. Reset mid-flight with 3 slots active → all outputs 0 asynchronously. After release, the first fire edge launches slot 0 with no cooldown.

Source files
------------

// File: rtl/bullet_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bullet_pkg
//  Description : Shared types and constants for the multi-slot bullet pool:
//                direction encoding, coordinate width, screen bounds and the
//                spawn-position helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package bullet_pkg;

  localparam int COORD_W      = 10;
  localparam int SCREEN_X_MAX = 639;
  localparam int SCREEN_Y_MAX = 479;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  // Centre a bullet on the tank along one axis. The sum is formed in 11-bit
  // two's complement; a negative result (small tank near the origin) clamps
  // to column/row 0.
  function automatic logic [COORD_W-1:0] spawn_coord(
    input logic [COORD_W-1:0] pos,
    input logic [COORD_W-1:0] size,
    input int                 half_bullet
  );
    logic [COORD_W-1:0] half_size;
    logic [COORD_W:0]   sum;
    half_size = size >> 1;
    sum = {1'b0, pos} + {1'b0, half_size} - (COORD_W+1)'(half_bullet);
    return sum[COORD_W] ? '0 : sum[COORD_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/bullet_slot.sv
`default_nettype none
// ============================================================================
//  Module      : bullet_slot
//  Description : One projectile slot. Holds position, direction and valid
//                flag; on a launch strobe it loads the spawn state, otherwise
//                an active slot is killed by hit, retires at the screen edge,
//                or advances STEP pixels per frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module bullet_slot
  import bullet_pkg::*;
#(
  parameter int STEP     = 5,
  parameter int X_MAX    = SCREEN_X_MAX,
  parameter int Y_MAX    = SCREEN_Y_MAX,
  parameter int BULLET_W = 8,
  parameter int BULLET_H = 8
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               i_launch,
  input  logic [COORD_W-1:0] i_spawn_x,
  input  logic [COORD_W-1:0] i_spawn_y,
  input  dir_t               i_spawn_dir,
  input  logic               i_hit,
  output logic               o_active,
  output logic               o_active_nxt,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output dir_t               o_dir
);

  // Edge comparisons use two guard bits so x + size + STEP cannot wrap.
  localparam int                 c_EXT_W    = COORD_W + 2;
  localparam logic [c_EXT_W-1:0] c_STEP_EXT = c_EXT_W'(STEP);
  localparam logic [c_EXT_W-1:0] c_DOWN_ADD = c_EXT_W'(BULLET_H + STEP);
  localparam logic [c_EXT_W-1:0] c_RIGHT_ADD = c_EXT_W'(BULLET_W + STEP);
  localparam logic [c_EXT_W-1:0] c_X_MAX    = c_EXT_W'(X_MAX);
  localparam logic [c_EXT_W-1:0] c_Y_MAX    = c_EXT_W'(Y_MAX);
  localparam logic [COORD_W-1:0] c_STEP     = COORD_W'(STEP);

  logic               r_active;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  dir_t               r_dir;

  logic               w_active_nxt;
  logic [COORD_W-1:0] w_x_nxt;
  logic [COORD_W-1:0] w_y_nxt;
  dir_t               w_dir_nxt;
  logic               w_at_edge;
  logic [c_EXT_W-1:0] w_x_ext;
  logic [c_EXT_W-1:0] w_y_ext;

  assign w_x_ext = {2'b00, r_x};
  assign w_y_ext = {2'b00, r_y};

  // Would one more step carry the bullet past the screen edge it is heading to?
  always_comb begin
    w_at_edge = 1'b0;
    case (r_dir)
      DIR_UP:    w_at_edge = (w_y_ext < c_STEP_EXT);
      DIR_DOWN:  w_at_edge = ((w_y_ext + c_DOWN_ADD) > c_Y_MAX);
      DIR_LEFT:  w_at_edge = (w_x_ext < c_STEP_EXT);
      DIR_RIGHT: w_at_edge = ((w_x_ext + c_RIGHT_ADD) > c_X_MAX);
      default:   w_at_edge = 1'b0;
    endcase
  end

  // Next-state: launch load, then hit / edge retirement, then movement.
  // A launch is only ever issued to a free slot, so it never races a hit.
  always_comb begin
    w_active_nxt = r_active;
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_dir_nxt    = r_dir;
    if (i_launch) begin
      w_active_nxt = 1'b1;
      w_x_nxt      = i_spawn_x;
      w_y_nxt      = i_spawn_y;
      w_dir_nxt    = i_spawn_dir;
    end else if (r_active) begin
      if (i_hit || w_at_edge) begin
        w_active_nxt = 1'b0;
      end else begin
        case (r_dir)
          DIR_UP:    w_y_nxt = r_y - c_STEP;
          DIR_DOWN:  w_y_nxt = r_y + c_STEP;
          DIR_LEFT:  w_x_nxt = r_x - c_STEP;
          DIR_RIGHT: w_x_nxt = r_x + c_STEP;
          default:   w_x_nxt = r_x;
        endcase
      end
    end
  end

  // Slot state register, cleared asynchronously by Reset.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_active <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_dir    <= DIR_UP;
    end else begin
      r_active <= w_active_nxt;
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_dir    <= w_dir_nxt;
    end
  end

  assign o_active     = r_active;
  assign o_active_nxt = w_active_nxt;
  assign o_x          = r_x;
  assign o_y          = r_y;
  assign o_dir        = r_dir;

endmodule
`default_nettype wire

// File: rtl/bullet_pool.sv
`default_nettype none
// ============================================================================
//  Module      : bullet_pool
//  Description : Multi-slot projectile manager. Detects fire edges, enforces
//                the launch cooldown, allocates the lowest free slot, and
//                packs per-slot state for the renderer and collision logic.
//                Build option BULLET_AUTOFIRE_EN: when defined, holding fire
//                launches every frame the cooldown allows (no edge detect).
//  Revision    : 1.0 - initial release
// ============================================================================
module bullet_pool
  import bullet_pkg::*;
#(
  parameter int NUM_BULLETS = 4,
  parameter int STEP        = 5,
  parameter int X_MAX       = SCREEN_X_MAX,
  parameter int Y_MAX       = SCREEN_Y_MAX,
  parameter int BULLET_W    = 8,
  parameter int BULLET_H    = 8,
  parameter int COOLDOWN    = 8
) (
  input  logic                           frame_clk,
  input  logic                           Reset,
  input  logic                           fire,
  input  logic [COORD_W-1:0]             tank_x,
  input  logic [COORD_W-1:0]             tank_y,
  input  logic [COORD_W-1:0]             tank_sx,
  input  logic [COORD_W-1:0]             tank_sy,
  input  logic [1:0]                     dir,
  input  logic [NUM_BULLETS-1:0]         hit,
  output logic [NUM_BULLETS-1:0]         active,
  output logic [NUM_BULLETS*COORD_W-1:0] bullet_x,
  output logic [NUM_BULLETS*COORD_W-1:0] bullet_y,
  output logic [NUM_BULLETS*2-1:0]       bullet_dir,
  output logic                           fire_ack,
  output logic                           pool_full
);

  localparam int              c_CD_W     = $clog2(COOLDOWN + 2);
  localparam logic [c_CD_W-1:0] c_CD_LOAD = c_CD_W'(COOLDOWN);

  logic [c_CD_W-1:0]      r_cd;
  logic                   r_ack;
  logic                   r_full;
  logic                   w_fire_req;
  logic                   w_launch;
  logic [NUM_BULLETS-1:0] w_grant;
  logic [NUM_BULLETS-1:0] w_active;
  logic [NUM_BULLETS-1:0] w_active_nxt;
  logic [COORD_W-1:0]     w_spawn_x;
  logic [COORD_W-1:0]     w_spawn_y;
  dir_t                   w_spawn_dir;

`ifdef BULLET_AUTOFIRE_EN
  assign w_fire_req = fire;
`else
  logic r_fire_q;

  // Previous fire level for rising-edge detection.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) r_fire_q <= 1'b0;
    else       r_fire_q <= fire;
  end

  assign w_fire_req = fire & ~r_fire_q;
`endif

  assign w_spawn_x   = spawn_coord(tank_x, tank_sx, BULLET_W >> 1);
  assign w_spawn_y   = spawn_coord(tank_y, tank_sy, BULLET_H >> 1);
  assign w_spawn_dir = dir_t'(dir);

  // Free slots are judged on the registered mask, so a slot freed by a hit
  // this frame only becomes allocatable next frame.
  assign w_launch = w_fire_req & (r_cd == '0) & ~(&w_active);

  // One-hot grant to the lowest-index free slot.
  always_comb begin
    logic w_seen;
    w_seen  = 1'b0;
    w_grant = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      w_grant[i] = ~w_active[i] & ~w_seen;
      w_seen     = w_seen | ~w_active[i];
    end
  end

  // Cooldown: reload on launch, otherwise count down and stick at zero.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset)               r_cd <= '0;
    else if (w_launch)       r_cd <= c_CD_LOAD;
    else if (r_cd != '0)     r_cd <= r_cd - 1'b1;
  end

  // One-frame launch acknowledge and registered full flag.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_ack  <= 1'b0;
      r_full <= 1'b0;
    end else begin
      r_ack  <= w_launch;
      r_full <= &w_active_nxt;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_BULLETS; gi++) begin : g_slot
      logic [COORD_W-1:0] w_x;
      logic [COORD_W-1:0] w_y;
      dir_t               w_dir;

      bullet_slot #(
        .STEP     (STEP),
        .X_MAX    (X_MAX),
        .Y_MAX    (Y_MAX),
        .BULLET_W (BULLET_W),
        .BULLET_H (BULLET_H)
      ) u_slot (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .i_launch     (w_launch & w_grant[gi]),
        .i_spawn_x    (w_spawn_x),
        .i_spawn_y    (w_spawn_y),
        .i_spawn_dir  (w_spawn_dir),
        .i_hit        (hit[gi]),
        .o_active     (w_active[gi]),
        .o_active_nxt (w_active_nxt[gi]),
        .o_x          (w_x),
        .o_y          (w_y),
        .o_dir        (w_dir)
      );

      assign bullet_x[gi*COORD_W +: COORD_W] = w_x;
      assign bullet_y[gi*COORD_W +: COORD_W] = w_y;
      assign bullet_dir[gi*2 +: 2]           = w_dir;
    end
  endgenerate

  assign active    = w_active;
  assign fire_ack  = r_ack;
  assign pool_full = r_full;

endmodule
`default_nettype wire

// File: tb/tb_bullet_pool.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bullet_pool
//  Description : Directed bench for bullet_pool. Launch expectations go into
//                a queue; a monitor pops one whenever fire_ack is seen and
//                checks the launched slot. Per-frame checks cover movement,
//                retirement, cooldown, pool-full, hit and async reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bullet_pool;

  localparam int NB = 4;

  logic          frame_clk;
  logic          Reset;
  logic          fire;
  logic [9:0]    tank_x, tank_y, tank_sx, tank_sy;
  logic [1:0]    dir;
  logic [NB-1:0] hit;
  logic [NB-1:0] active;
  logic [NB*10-1:0] bullet_x, bullet_y;
  logic [NB*2-1:0]  bullet_dir;
  logic          fire_ack;
  logic          pool_full;

  typedef struct {
    int         slot;
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] d;
    logic [3:0] mask;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  bullet_pool #(
    .NUM_BULLETS(NB), .STEP(5), .X_MAX(639), .Y_MAX(479),
    .BULLET_W(8), .BULLET_H(8), .COOLDOWN(8)
  ) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .fire      (fire),
    .tank_x    (tank_x),
    .tank_y    (tank_y),
    .tank_sx   (tank_sx),
    .tank_sy   (tank_sy),
    .dir       (dir),
    .hit       (hit),
    .active    (active),
    .bullet_x  (bullet_x),
    .bullet_y  (bullet_y),
    .bullet_dir(bullet_dir),
    .fire_ack  (fire_ack),
    .pool_full (pool_full)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  function automatic logic [9:0] bx(input int i);
    return bullet_x[i*10 +: 10];
  endfunction

  function automatic logic [9:0] by(input int i);
    return bullet_y[i*10 +: 10];
  endfunction

  function automatic logic [1:0] bd(input int i);
    return bullet_dir[i*2 +: 2];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply inputs for the next posedge, then wait to the following negedge.
  task automatic frame(input logic f, input logic [NB-1:0] h);
    fire = f;
    hit  = h;
    @(negedge frame_clk);
  endtask

  task automatic set_tank(input int x, input int y, input int sx, input int sy, input logic [1:0] d);
    tank_x  = 10'(x);
    tank_y  = 10'(y);
    tank_sx = 10'(sx);
    tank_sy = 10'(sy);
    dir     = d;
  endtask

  task automatic expect_launch(input int s, input int x, input int y, input logic [1:0] d, input logic [3:0] m);
    exp_t e;
    e.slot = s; e.x = 10'(x); e.y = 10'(y); e.d = d; e.mask = m;
    exp_q.push_back(e);
  endtask

  // Monitor: every acknowledged launch must match the next queued expectation.
  always @(negedge frame_clk) begin
    if (!Reset && fire_ack) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ack: got ack with mask %b, expected no ack", active);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("launch_mask", 64'(active), 64'(e.mask));
        chk("launch_x",    64'(bx(e.slot)), 64'(e.x));
        chk("launch_y",    64'(by(e.slot)), 64'(e.y));
        chk("launch_dir",  64'(bd(e.slot)), 64'(e.d));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1;
    fire  = 1'b0;
    hit   = '0;
    set_tank(0, 0, 0, 0, 2'b00);
    @(negedge frame_clk);
    chk("rst_active", 64'(active), 0);
    chk("rst_ack",    64'(fire_ack), 0);
    chk("rst_full",   64'(pool_full), 0);
    chk("rst_x",      64'(bullet_x), 0);
    chk("rst_y",      64'(bullet_y), 0);
    chk("rst_dir",    64'(bullet_dir), 0);
    Reset = 1'b0;
    @(negedge frame_clk);

    // 1: launch upward from (100,200) 16x16 -> spawn (104,204)
    set_tank(100, 200, 16, 16, 2'b00);
    expect_launch(0, 104, 204, 2'b00, 4'b0001);
    frame(1'b1, '0);
    chk("t1_ack", 64'(fire_ack), 1);
    frame(1'b0, '0);
    chk("t1_ack_drop", 64'(fire_ack), 0);
    chk("t1_y_move",   64'(by(0)), 199);

    // 2: fly up to y=4, then retire with position held
    for (int k = 1; k <= 39; k++) begin
      frame(1'b0, '0);
      chk("t2_y", 64'(by(0)), 64'(199 - 5*k));
    end
    chk("t2_alive", 64'(active[0]), 1);
    frame(1'b0, '0);
    chk("t2_retired", 64'(active[0]), 0);
    chk("t2_y_hold",  64'(by(0)), 4);

    // 3: cooldown blocks an edge 3 frames later; edge at frame 9 takes slot 1
    set_tank(300, 100, 20, 10, 2'b11);
    expect_launch(0, 306, 101, 2'b11, 4'b0001);
    frame(1'b1, '0);                       // frame 0
    frame(1'b0, '0);
    frame(1'b0, '0);
    frame(1'b1, '0);                       // frame 3, dropped
    chk("t3_drop_ack",    64'(fire_ack), 0);
    chk("t3_drop_active", 64'(active), 4'b0001);
    for (int k = 0; k < 5; k++) frame(1'b0, '0);
    expect_launch(1, 306, 101, 2'b11, 4'b0011);
    frame(1'b1, '0);                       // frame 9
    chk("t3_ack9", 64'(fire_ack), 1);
    chk("t3_x0",   64'(bx(0)), 351);

    // 4: fill the pool, drop an edge, free slot 2 by hit and reuse it
    set_tank(50, 50, 16, 16, 2'b01);
    for (int k = 0; k < 8; k++) frame(1'b0, '0);
    expect_launch(2, 54, 54, 2'b01, 4'b0111);
    frame(1'b1, '0);
    for (int k = 0; k < 8; k++) frame(1'b0, '0);
    expect_launch(3, 54, 54, 2'b01, 4'b1111);
    frame(1'b1, '0);
    chk("t4_full", 64'(pool_full), 1);
    for (int k = 0; k < 8; k++) frame(1'b0, '0);
    frame(1'b1, '0);                       // full pool, dropped
    chk("t4_full_ack",    64'(fire_ack), 0);
    chk("t4_full_active", 64'(active), 4'b1111);
    chk("t4_full_flag",   64'(pool_full), 1);
    chk("t4_y3",          64'(by(3)), 99);
    chk("t4_y2",          64'(by(2)), 144);
    frame(1'b0, '0);
    frame(1'b1, 4'b0100);                  // hit and edge together: no reuse yet
    chk("t4_hit_active", 64'(active), 4'b1011);
    chk("t4_hit_ack",    64'(fire_ack), 0);
    chk("t4_hit_full",   64'(pool_full), 0);
    chk("t4_hit_y2",     64'(by(2)), 149);
    frame(1'b0, '0);
    chk("t4_idle_y2",    64'(by(2)), 149);
    set_tank(200, 300, 16, 16, 2'b10);
    expect_launch(2, 204, 304, 2'b10, 4'b1111);
    frame(1'b1, '0);
    chk("t4_reuse_full", 64'(pool_full), 1);
    frame(1'b0, 4'b1000);
    chk("t4_three", 64'(active), 4'b0111);

    // 6: asynchronous reset with three slots in flight
    hit = '0;
    #2 Reset = 1'b1;
    #1;
    chk("t6_rst_active", 64'(active), 0);
    chk("t6_rst_x",      64'(bullet_x), 0);
    chk("t6_rst_y",      64'(bullet_y), 0);
    chk("t6_rst_dir",    64'(bullet_dir), 0);
    chk("t6_rst_full",   64'(pool_full), 0);
    @(negedge frame_clk);
    Reset = 1'b0;

    // 5 (+6): corner tank spawn clamps to (0,0); no leftover cooldown
    set_tank(0, 0, 4, 4, 2'b10);
    expect_launch(0, 0, 0, 2'b10, 4'b0001);
    frame(1'b1, '0);
    chk("t5_ack", 64'(fire_ack), 1);
    frame(1'b0, '0);
    chk("t5_retired", 64'(active), 0);
    chk("t5_x_hold",  64'(bx(0)), 0);
    chk("t5_y_hold",  64'(by(0)), 0);
    chk("t5_ack_off", 64'(fire_ack), 0);

    frame(1'b0, '0);
    chk("queue_empty", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
